// File: rtl/mux_pkg.sv
// Shared constants for the 4:1 select tree.
// Select codes map {s1,s0} onto the data input chosen.
package mux_pkg;

    localparam int DEFAULT_WIDTH = 1;

    localparam logic [1:0] SEL_I0 = 2'b00;
    localparam logic [1:0] SEL_I1 = 2'b01;
    localparam logic [1:0] SEL_I2 = 2'b10;
    localparam logic [1:0] SEL_I3 = 2'b11;

endpackage

// File: rtl/mux_2x1.sv
// Single 2:1 steer stage, building block of the 4:1 tree.
// Plain ?: so an unknown select merges agreeing bits.
module mux_2x1
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mux_4x1.sv
// 4:1 selector as a tree of three 2:1 stages.
// y is purely combinational; y_q is its registered copy.
module mux_4x1
    import mux_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);

    logic [WIDTH-1:0] stage_a;
    logic [WIDTH-1:0] stage_b;

    mux_2x1 #(.WIDTH(WIDTH)) u_lo (
        .a (i0),
        .b (i1),
        .s (s0),
        .y (stage_a)
    );

    mux_2x1 #(.WIDTH(WIDTH)) u_hi (
        .a (i2),
        .b (i3),
        .s (s0),
        .y (stage_b)
    );

    mux_2x1 #(.WIDTH(WIDTH)) u_out (
        .a (stage_a),
        .b (stage_b),
        .s (s1),
        .y (y)
    );

    // Capture the mux result each cycle; reset forces the known value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= RST_VAL;
        end else begin
            y_q <= y;
        end
    end

endmodule

// File: tb/tb_mux_4x1.sv
// Directed and randomized checks of the 4:1 selector.
// Runs a 1-bit and an 8-bit instance side by side.
module tb_mux_4x1;
    import mux_pkg::*;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic       s1;
    logic       s0;
    logic       a0, a1, a2, a3;
    logic       y1, yq1;
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] y8, yq8;

    int vectors;
    int miscompares;

    mux_4x1 #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .i0    (a0),
        .i1    (a1),
        .i2    (a2),
        .i3    (a3),
        .s1    (s1),
        .s0    (s0),
        .y     (y1),
        .y_q   (yq1)
    );

    mux_4x1 #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .i0    (b0),
        .i1    (b1),
        .i2    (b2),
        .i3    (b3),
        .s1    (s1),
        .s0    (s0),
        .y     (y8),
        .y_q   (yq8)
    );

    // Free-running clock, gated so some phases see no edges at all.
    always #5 clk = clk_en ? ~clk : clk;

    // Reference: every input a possibly-unknown select could pick is a
    // candidate; bits on which candidates disagree become X.
    function automatic logic [7:0] ref_sel(
        input logic [7:0] d0, input logic [7:0] d1,
        input logic [7:0] d2, input logic [7:0] d3,
        input logic hi, input logic lo
    );
        logic [7:0] cand [4];
        logic [7:0] r;
        logic       any;
        logic [1:0] code;
        cand[0] = d0;
        cand[1] = d1;
        cand[2] = d2;
        cand[3] = d3;
        r   = '0;
        any = 1'b0;
        for (int k = 0; k < 4; k++) begin
            code = 2'(k);
            if (($isunknown(hi) || hi == code[1]) &&
                ($isunknown(lo) || lo == code[0])) begin
                if (!any) begin
                    r   = cand[k];
                    any = 1'b1;
                end else begin
                    for (int b = 0; b < 8; b++)
                        if (r[b] !== cand[k][b]) r[b] = 1'bx;
                end
            end
        end
        return r;
    endfunction

    task automatic check(input string tag,
                         input logic [7:0] obs,
                         input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [7:0] exh_exp;
    logic [7:0] wide_exp [4];
    logic [1:0] sel;

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk    = 1'b0;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        {s1, s0} = SEL_I0;
        {a0, a1, a2, a3} = 4'b0;
        {b0, b1, b2, b3} = '0;
        #1;
        check("reset_yq1", {7'd0, yq1}, 8'h00);
        check("reset_yq8", yq8, 8'h00);
        #2;
        rst_n = 1'b1;

        // Exhaustive select sweep on the 1-bit instance.
        exh_exp = 8'b0110;
        {a0, a1, a2, a3} = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            {s1, s0} = 2'(k);
            #5;
            check($sformatf("exh_sel%0d", k), {7'd0, y1},
                  {7'd0, exh_exp[k]});
        end

        // Random inputs with the clock stopped: y follows, y_q untouched.
        for (int n = 0; n < 10; n++) begin
            a0 = 1'($urandom); a1 = 1'($urandom);
            a2 = 1'($urandom); a3 = 1'($urandom);
            b0 = 8'($urandom); b1 = 8'($urandom);
            b2 = 8'($urandom); b3 = 8'($urandom);
            s1 = 1'($urandom); s0 = 1'($urandom);
            #10;
            check($sformatf("rand1_%0d", n), {7'd0, y1},
                  ref_sel({7'd0, a0}, {7'd0, a1},
                          {7'd0, a2}, {7'd0, a3}, s1, s0));
            check($sformatf("rand8_%0d", n), y8,
                  ref_sel(b0, b1, b2, b3, s1, s0));
            check($sformatf("rand_yq8_%0d", n), yq8, 8'h00);
        end
        check("rand_yq1", {7'd0, yq1}, 8'h00);

        // Async reset: load y_q with 1, then drop rst_n mid-cycle.
        {s1, s0} = SEL_I0;
        a0 = 1'b1;
        b0 = 8'h5A;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_yq1", {7'd0, yq1}, 8'h01);
        check("pre_rst_yq8", yq8, 8'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_yq1", {7'd0, yq1}, 8'h00);
        check("async_rst_yq8", yq8, 8'h00);
        check("async_rst_y1", {7'd0, y1}, 8'h01);
        @(posedge clk);
        #1;
        check("rst_hold_yq1", {7'd0, yq1}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // One-cycle register latency.
        {s1, s0} = SEL_I2;
        a2 = 1'b1;
        @(posedge clk);
        #1;
        check("lat_capture_yq1", {7'd0, yq1}, 8'h01);
        a0 = 1'b0;
        {s1, s0} = SEL_I0;
        #1;
        check("lat_y_now", {7'd0, y1}, 8'h00);
        check("lat_yq_hold", {7'd0, yq1}, 8'h01);
        @(posedge clk);
        #1;
        check("lat_yq_next", {7'd0, yq1}, 8'h00);

        // Wide datapath sweep.
        b0 = 8'hA5; b1 = 8'h3C; b2 = 8'hF0; b3 = 8'h0F;
        wide_exp[0] = 8'hA5; wide_exp[1] = 8'h3C;
        wide_exp[2] = 8'hF0; wide_exp[3] = 8'h0F;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            {s1, s0} = sel;
            #1;
            check($sformatf("wide_sel%0d", k), y8, wide_exp[k]);
        end
        @(posedge clk);
        #1;
        check("wide_yq8", yq8, 8'h0F);
        clk_en = 1'b0;

        // Unknown select LSB: agreeing inputs still resolve.
        s1 = 1'b0;
        s0 = 1'bx;
        a0 = 1'b1;
        a1 = 1'b1;
        #1;
        check("xsel_agree", {7'd0, y1}, 8'h01);
        a0 = 1'b0;
        #1;
        check("xsel_differ", {7'd0, y1},
              ref_sel({7'd0, a0}, {7'd0, a1},
                      {7'd0, a2}, {7'd0, a3}, s1, s0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_4x1.md
Name: mux_4x1

Overview:
- 4-to-1 selector built as a tree of three 2-to-1 stages.
- Combinational output y follows inputs i0..i3 under 2-bit select {s1,s0}.
- Registered copy y_q is provided for timing-closed downstream consumers.
- Leaf datapath primitive, used wherever a small select-driven steer is needed.

Parameters:
- WIDTH, 1, bit width of each data input and of both outputs (legal range 1..64).
- RST_VAL, {WIDTH{1'b0}}, value loaded into y_q while reset is asserted.

Ports:
- clk  input  1  system clock; rising edge samples y into y_q.
- rst_n  input  1  reset, asynchronous, active-low; clears y_q only.
- i0  input  WIDTH  data, selected when {s1,s0}=2'b00.
- i1  input  WIDTH  data, selected when {s1,s0}=2'b01.
- i2  input  WIDTH  data, selected when {s1,s0}=2'b10.
- i3  input  WIDTH  data, selected when {s1,s0}=2'b11.
- s1  input  1  select MSB; drives the final 2:1 stage.
- s0  input  1  select LSB; drives both first-stage 2:1 muxes.
- y  output  WIDTH  combinational mux result.
- y_q  output  WIDTH  y registered on clk.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. Reset affects only y_q.
- Decomposition of y, purely combinational, zero latency:
  - Stage A = s0 ? i1 : i0.
  - Stage B = s0 ? i3 : i2.
  - y = s1 ? B : A.
- y never depends on clk or rst_n.
- y must settle within the same delta/timestep as any input change. No latches, no storage on the y path.
- X/Z on a select bit:
  - y bits where both candidate inputs agree must resolve to that value.
  - Otherwise y is X. This is the natural result of a ?: tree and must not be masked.
- y_q:
  - On negedge rst_n, y_q = RST_VAL immediately, independent of clk.
  - While rst_n=0, y_q holds RST_VAL.
  - On each posedge clk with rst_n=1, y_q <= y (1-cycle latency).
- Reset release coinciding with a clk edge: y_q stays RST_VAL on that edge and captures on the next edge. Standard async-assert, flop-level behaviour; rst_n is synchronised upstream.
- Inputs changing between clock edges affect y immediately and y_q only at the next posedge.
- Width rule: all data ports and outputs are exactly WIDTH bits. No extension or truncation.

Decomposition:
- Package mux_pkg:
  - localparam DEFAULT_WIDTH = 1.
  - Select encoding constants SEL_I0=2'b00, SEL_I1=2'b01, SEL_I2=2'b10, SEL_I3=2'b11.
- Sub-module mux_2x1 (params WIDTH; ports a, b, s, y; y = s ? b : a).
- mux_4x1 instantiates mux_2x1 three times (u_lo, u_hi, u_out) plus one always_ff for y_q.

Test Plan:
- Exhaustive select, WIDTH=1: i0=0,i1=1,i2=1,i3=0; step {s1,s0} 00,01,10,11 at 5-unit spacing -> y = 0,1,1,0, checked 5 units after each change.
- Random stimulus: 10 iterations of random i0..i3, s1, s0, each held 10 units, no clock toggling -> y equals the reference model i[{s1,s0}] at every check; y_q stays at its reset value.
- Async reset: run clk; drive y=1 and let y_q=1; drop rst_n mid-cycle -> y_q=0 immediately, before the next edge; y unaffected.
- Register latency: rst_n=1; sel=2'b10, i2=1 before edge N -> y_q=1 after edge N. Change sel to 00 with i0=0 just after edge N -> y=0 at once, y_q stays 1 until edge N+1.
- Wide datapath, WIDTH=8: i0=8'hA5, i1=8'h3C, i2=8'hF0, i3=8'h0F; sweep selects -> y = A5, 3C, F0, 0F.
- X select: s0=1'bx, s1=0, i0=i1=1 -> y=1; with i0=0, i1=1 -> y=x.
